// File: rtl/nios_io_pkg.sv
// rtl/nios_io_pkg.sv - shared channel counts, debounce state enum and tick derivation
package nios_io_pkg;

  // Channel counts shared with the Qsys top wrapper.
  localparam int N_BUTTONS  = 4;
  localparam int N_SWITCHES = 10;

  // Per-channel debounce state.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_t;

  // Clock cycles between debounce sample ticks.
  function automatic int tick_cycles(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// rtl/io_debounce_bit.sv - one channel: 2-FF sync, tick debounce FSM, edge pulses
module io_debounce_bit
  import nios_io_pkg::*;
#(
  parameter int DB_TICKS = 10,
  parameter bit INVERT   = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_TICKS + 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  db_state_t     state;
  db_state_t     state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          db_next;
  logic          accept;

  // Two-flop synchroniser; resets to the released pin level so no spurious edge follows reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= INVERT;
      sync2 <= INVERT;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ INVERT;

  // Final tick of a pending change that survived every sample.
  assign accept = (state == ST_PENDING) && (s != db) && tick &&
                  (cnt == CW'(DB_TICKS - 1));

  // State, counter, debounced level and registered edge pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_STABLE;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      db    <= db_next;
      rise  <= db_next & ~db;
      fall  <= ~db_next & db;
    end
  end

  // Next state and counter: any cycle agreeing with db aborts a pending change.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_STABLE: begin
        cnt_next = '0;
        if (s != db) state_next = ST_PENDING;
      end
      ST_PENDING: begin
        if (s == db) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (accept) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Debounced level takes the synchronised input only on acceptance.
  always_comb begin
    db_next = db;
    if (accept) db_next = s;
  end

endmodule

// File: rtl/nios_input_conditioner.sv
// rtl/nios_input_conditioner.sv - shared prescaler plus per-pin debounce for keys and switches
module nios_input_conditioner
  import nios_io_pkg::*;
#(
  parameter int N_BUTTONS      = nios_io_pkg::N_BUTTONS,
  parameter int N_SWITCHES     = nios_io_pkg::N_SWITCHES,
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1_000,
  parameter int DB_TICKS       = 10,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [N_BUTTONS-1:0]  key_n_i,
  input  logic [N_SWITCHES-1:0] sw_i,
  output logic [N_BUTTONS-1:0]  button_o,
  output logic [N_SWITCHES-1:0] switch_o,
  output logic [N_BUTTONS-1:0]  btn_press_o,
  output logic [N_BUTTONS-1:0]  btn_release_o
);

  localparam int TICK_CYCLES = tick_cycles(CLK_HZ, TICK_HZ);
  localparam int PW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]         presc;
  logic                  tick;
  logic [N_SWITCHES-1:0] sw_rise_unused;
  logic [N_SWITCHES-1:0] sw_fall_unused;

  assign tick = (presc == PW'(TICK_CYCLES - 1));

  // Free-running prescaler shared by every channel; tick marks the wrap cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    io_debounce_bit #(
      .DB_TICKS (DB_TICKS),
      .INVERT   (BTN_ACTIVE_LOW)
    ) u_btn (
      .clk    (clk_clk),
      .resetn (reset_reset_n),
      .tick   (tick),
      .raw    (key_n_i[i]),
      .db     (button_o[i]),
      .rise   (btn_press_o[i]),
      .fall   (btn_release_o[i])
    );
  end

  for (genvar i = 0; i < N_SWITCHES; i++) begin : g_sw
    io_debounce_bit #(
      .DB_TICKS (DB_TICKS),
      .INVERT   (1'b0)
    ) u_sw (
      .clk    (clk_clk),
      .resetn (reset_reset_n),
      .tick   (tick),
      .raw    (sw_i[i]),
      .db     (switch_o[i]),
      .rise   (sw_rise_unused[i]),
      .fall   (sw_fall_unused[i])
    );
  end

endmodule

// File: tb/tb_nios_input_conditioner.sv
// tb/tb_nios_input_conditioner.sv - scoreboard bench for debounce levels, pulses and latency
module tb_nios_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_n;
  logic [9:0] sw;
  logic [3:0] button;
  logic [9:0] switch_lvl;
  logic [3:0] press;
  logic [3:0] rel;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    string      tag;
    int         drive_cyc;
    logic [3:0] btn;
    logic [9:0] swv;
    logic [3:0] press;
    logic [3:0] rel;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         lat;
  logic [3:0] prev_b = '0;
  logic [9:0] prev_s = '0;

  nios_input_conditioner #(
    .N_BUTTONS      (4),
    .N_SWITCHES     (10),
    .CLK_HZ         (1000),
    .TICK_HZ        (100),
    .DB_TICKS       (3),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .key_n_i       (key_n),
    .sw_i          (sw),
    .button_o      (button),
    .switch_o      (switch_lvl),
    .btn_press_o   (press),
    .btn_release_o (rel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [3:0] b, input logic [9:0] s,
                          input logic [3:0] p, input logic [3:0] r);
    exp_t x;
    x.tag = tag; x.drive_cyc = cyc; x.btn = b; x.swv = s; x.press = p; x.rel = r;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_button"},  32'(button),     0);
    check_eq({tag, "_switch"},  32'(switch_lvl), 0);
    check_eq({tag, "_press"},   32'(press),      0);
    check_eq({tag, "_release"}, 32'(rel),        0);
  endtask

  // Every output change must match the oldest expected event, within the latency window.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (button !== prev_b || switch_lvl !== prev_s || |press || |rel) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_event", {press, rel, button, switch_lvl}, 0);
        end else begin
          e   = sb.pop_front();
          lat = cyc - e.drive_cyc;
          check_eq({e.tag, "_button"},  32'(button),     32'(e.btn));
          check_eq({e.tag, "_switch"},  32'(switch_lvl), 32'(e.swv));
          check_eq({e.tag, "_press"},   32'(press),      32'(e.press));
          check_eq({e.tag, "_release"}, 32'(rel),        32'(e.rel));
          check_eq({e.tag, "_latency_in_23_33"}, 32'(lat >= 23 && lat <= 33), 1);
          if (!(lat >= 23 && lat <= 33)) $display("  latency observed %0d cycles", lat);
        end
      end
    end
    prev_b = button;
    prev_s = switch_lvl;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_n = 4'hF;
    sw    = '0;

    // Reset held 5 cycles: outputs zero during and after.
    repeat (5) begin
      @(negedge clk);
      check_all_zero("reset_during");
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (40) @(negedge clk);
    check_all_zero("reset_after");

    // Clean press on key0.
    @(negedge clk);
    key_n = 4'b1110;
    push_exp("press_k0", 4'b0001, 10'h000, 4'b0001, 4'b0000);
    repeat (60) @(negedge clk);
    wait_idle("press_k0", 20);

    // Bouncing key1, 7-cycle toggles, then held low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_n[1] = ~key_n[1];
      repeat (6) @(negedge clk);
    end
    check_eq("bounce_button1_low", 32'(button[1]), 0);
    @(negedge clk);
    key_n[1] = 1'b0;
    push_exp("bounce_k1", 4'b0011, 10'h000, 4'b0010, 4'b0000);
    wait_idle("bounce_k1", 60);

    // Switch step, all bits together, no button pulses.
    @(negedge clk);
    sw = 10'h2A5;
    push_exp("switch_step", 4'b0011, 10'h2A5, 4'b0000, 4'b0000);
    wait_idle("switch_step", 60);

    // Release key0 and press key3 in the same cycle.
    @(negedge clk);
    key_n = 4'b0101;
    push_exp("simul_k0_k3", 4'b1010, 10'h2A5, 4'b1000, 4'b0001);
    wait_idle("simul_k0_k3", 60);

    // Release remaining keys and drop switches together.
    @(negedge clk);
    key_n = 4'hF;
    sw    = '0;
    push_exp("cleanup", 4'b0000, 10'h000, 4'b0000, 4'b1010);
    wait_idle("cleanup", 60);

    // Reset mid-pending discards the change; full debounce after release.
    @(negedge clk);
    key_n = 4'b1011;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midreset_during");
    rst_n = 1'b1;
    push_exp("midreset_k2", 4'b0100, 10'h000, 4'b0100, 4'b0000);
    @(negedge clk);
    check_eq("midreset_button2_after", 32'(button[2]), 0);
    wait_idle("midreset_k2", 60);

    repeat (40) @(negedge clk);
    check_eq("final_queue_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
